// File: rtl/pipelined_processor_if.sv
// Instruction- and data-memory bus bundle for pipelined_processor.
// The core drives it through the master modport; the memories sit on the slave side.
interface pipelined_processor_if;
  logic [31:0] instruction;
  logic [31:0] pc_addr;
  logic [1:0]  im_command;
  logic [31:0] mem2proc_data;
  logic [31:0] proc2Dmem_addr;
  logic [1:0]  proc2Dmem_command;
  logic [31:0] proc2mem_data;

  modport master (
    input  instruction, mem2proc_data,
    output pc_addr, im_command, proc2Dmem_addr, proc2Dmem_command, proc2mem_data
  );

  modport slave (
    output instruction, mem2proc_data,
    input  pc_addr, im_command, proc2Dmem_addr, proc2Dmem_command, proc2mem_data
  );
endinterface

// File: rtl/pipelined_processor.sv
// Five-stage in-order RV32I-subset pipeline (IF/ID/EX/MEM/WB) with commit trace ports.
// Define FORWARDING_EN for EX-stage operand forwarding; otherwise ID stalls on every RAW hazard.
module pipelined_processor #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  pipelined_processor_if.master bus,
  output logic [4:0]            pipeline_commit_wr_idx,
  output logic [31:0]           pipeline_commit_wr_data,
  output logic [31:0]           pipeline_commit_NPC,
  output logic                  pipeline_commit_wr,
  output logic [31:0]           if_PC_out,
  output logic [31:0]           if_NPC_out,
  output logic [31:0]           if_IR_out,
  output logic [31:0]           if_id_PC,
  output logic [31:0]           if_id_NPC,
  output logic [31:0]           if_id_IR,
  output logic [31:0]           id_ex_PC,
  output logic [31:0]           id_ex_NPC,
  output logic [31:0]           id_ex_IR,
  output logic [31:0]           ex_mem_NPC,
  output logic [31:0]           ex_mem_IR,
  output logic [31:0]           mem_wb_NPC,
  output logic [31:0]           mem_wb_IR
);
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [1:0]  BUS_NONE  = 2'd0;
  localparam logic [1:0]  BUS_LOAD  = 2'd1;
  localparam logic [1:0]  BUS_STORE = 2'd2;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011, OP_ST  = 7'b0100011, OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4, ALU_SLT = 3'd5, ALU_PB  = 3'd6;

  typedef struct packed {
    logic        wr;      // writes a nonzero rd
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use1;
    logic        use2;
    logic        ld;
    logic        st;
    logic        br;
    logic        bne;
    logic        jal;
    logic        imm_b;
    logic [2:0]  alu;
    logic [31:0] imm;
  } dec_t;

  function automatic logic [2:0] f3_alu(input logic [2:0] f3);
    case (f3)
      3'b010:  return ALU_SLT;
      3'b100:  return ALU_XOR;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  // Unsupported encodings decode to all-zero control, i.e. they flow through as NOPs.
  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    d     = '0;
    d.rd  = ir[11:7];
    d.rs1 = ir[19:15];
    d.rs2 = ir[24:20];
    case (ir[6:0])
      OP_LUI: begin
        d.wr = 1'b1; d.imm_b = 1'b1; d.alu = ALU_PB; d.imm = {ir[31:12], 12'b0};
      end
      OP_IMM: if (ir[14:12] inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111}) begin
        d.wr = 1'b1; d.use1 = 1'b1; d.imm_b = 1'b1; d.alu = f3_alu(ir[14:12]);
        d.imm = {{20{ir[31]}}, ir[31:20]};
      end
      OP_REG: if ((ir[31:25] == 7'h00 && ir[14:12] inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111})
                  || (ir[31:25] == 7'h20 && ir[14:12] == 3'b000)) begin
        d.wr = 1'b1; d.use1 = 1'b1; d.use2 = 1'b1;
        d.alu = ir[30] ? ALU_SUB : f3_alu(ir[14:12]);
      end
      OP_LD: if (ir[14:12] == 3'b010) begin
        d.wr = 1'b1; d.use1 = 1'b1; d.ld = 1'b1; d.imm_b = 1'b1;
        d.imm = {{20{ir[31]}}, ir[31:20]};
      end
      OP_ST: if (ir[14:12] == 3'b010) begin
        d.use1 = 1'b1; d.use2 = 1'b1; d.st = 1'b1; d.imm_b = 1'b1;
        d.imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      end
      OP_BR: if (ir[14:13] == 2'b00) begin
        d.use1 = 1'b1; d.use2 = 1'b1; d.br = 1'b1; d.bne = ir[12];
        d.imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      end
      OP_JAL: begin
        d.wr = 1'b1; d.jal = 1'b1;
        d.imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      end
      default: d.wr = 1'b0;
    endcase
    if (d.rd == 5'd0) d.wr = 1'b0;
    return d;
  endfunction

  function automatic logic raw(input dec_t p, input dec_t c);
    return p.wr && ((c.use1 && c.rs1 == p.rd) || (c.use2 && c.rs2 == p.rd));
  endfunction

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_pc_q, if_id_pc_d, if_id_npc_q, if_id_npc_d, if_id_ir_q, if_id_ir_d;
  logic [31:0] id_ex_pc_q, id_ex_pc_d, id_ex_npc_q, id_ex_npc_d, id_ex_ir_q, id_ex_ir_d;
  logic [31:0] id_ex_rs1v_q, id_ex_rs1v_d, id_ex_rs2v_q, id_ex_rs2v_d;
  logic [31:0] ex_mem_npc_q, ex_mem_ir_q, ex_mem_res_q, ex_mem_sdata_q;
  logic [31:0] mem_wb_npc_q, mem_wb_ir_q, mem_wb_res_q;
  logic [31:0] rf_q [1:31];

  dec_t        dec_id, dec_ex, dec_mem, dec_wb;
  logic [31:0] id_rs1, id_rs2, ex_rs1, ex_rs2, alu_b, alu_out, ex_res, target, mem_res;
  logic        stall, taken;
  logic        unused_dec;

  assign dec_id  = decode(if_id_ir_q);
  assign dec_ex  = decode(id_ex_ir_q);
  assign dec_mem = decode(ex_mem_ir_q);
  assign dec_wb  = decode(mem_wb_ir_q);
  assign unused_dec = ^{dec_id, dec_ex, dec_mem, dec_wb};

  // ID register read with same-cycle WB bypass.
  assign id_rs1 = (dec_wb.wr && dec_wb.rd == dec_id.rs1) ? mem_wb_res_q :
                  (dec_id.rs1 == 5'd0) ? 32'd0 : rf_q[dec_id.rs1];
  assign id_rs2 = (dec_wb.wr && dec_wb.rd == dec_id.rs2) ? mem_wb_res_q :
                  (dec_id.rs2 == 5'd0) ? 32'd0 : rf_q[dec_id.rs2];

`ifdef FORWARDING_EN
  assign stall = dec_ex.ld && raw(dec_ex, dec_id);
`else
  assign stall = raw(dec_ex, dec_id) || raw(dec_mem, dec_id);
`endif

  always_comb begin
    ex_rs1 = id_ex_rs1v_q;
    ex_rs2 = id_ex_rs2v_q;
`ifdef FORWARDING_EN
    // MEM/WB first so the younger EX/MEM result overrides it.
    if (dec_wb.wr  && dec_wb.rd  == dec_ex.rs1) ex_rs1 = mem_wb_res_q;
    if (dec_mem.wr && dec_mem.rd == dec_ex.rs1) ex_rs1 = ex_mem_res_q;
    if (dec_wb.wr  && dec_wb.rd  == dec_ex.rs2) ex_rs2 = mem_wb_res_q;
    if (dec_mem.wr && dec_mem.rd == dec_ex.rs2) ex_rs2 = ex_mem_res_q;
`endif
  end

  assign alu_b = dec_ex.imm_b ? dec_ex.imm : ex_rs2;

  always_comb begin
    case (dec_ex.alu)
      ALU_SUB: alu_out = ex_rs1 - alu_b;
      ALU_AND: alu_out = ex_rs1 & alu_b;
      ALU_OR:  alu_out = ex_rs1 | alu_b;
      ALU_XOR: alu_out = ex_rs1 ^ alu_b;
      ALU_SLT: alu_out = {31'd0, $signed(ex_rs1) < $signed(alu_b)};
      ALU_PB:  alu_out = alu_b;
      default: alu_out = ex_rs1 + alu_b;
    endcase
  end

  assign ex_res  = dec_ex.jal ? id_ex_npc_q : alu_out;
  assign target  = id_ex_pc_q + dec_ex.imm;
  assign taken   = dec_ex.jal || (dec_ex.br && ((ex_rs1 == ex_rs2) ^ dec_ex.bne));
  assign mem_res = dec_mem.ld ? bus.mem2proc_data : ex_mem_res_q;

  // Flush has priority over the load-use/RAW stall.
  always_comb begin
    pc_d         = pc_q + 32'd4;
    if_id_pc_d   = pc_q;
    if_id_npc_d  = pc_q + 32'd4;
    if_id_ir_d   = bus.instruction;
    id_ex_pc_d   = if_id_pc_q;
    id_ex_npc_d  = if_id_npc_q;
    id_ex_ir_d   = if_id_ir_q;
    id_ex_rs1v_d = id_rs1;
    id_ex_rs2v_d = id_rs2;
    if (taken) begin
      pc_d        = target;
      if_id_pc_d  = 32'd0;
      if_id_npc_d = 32'd0;
      if_id_ir_d  = NOP;
    end else if (stall) begin
      pc_d        = pc_q;
      if_id_pc_d  = if_id_pc_q;
      if_id_npc_d = if_id_npc_q;
      if_id_ir_d  = if_id_ir_q;
    end
    if (taken || stall) begin
      id_ex_pc_d   = 32'd0;
      id_ex_npc_d  = 32'd0;
      id_ex_ir_d   = NOP;
      id_ex_rs1v_d = 32'd0;
      id_ex_rs2v_d = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q           <= RESET_PC;
      if_id_pc_q     <= '0;
      if_id_npc_q    <= '0;
      if_id_ir_q     <= NOP;
      id_ex_pc_q     <= '0;
      id_ex_npc_q    <= '0;
      id_ex_ir_q     <= NOP;
      id_ex_rs1v_q   <= '0;
      id_ex_rs2v_q   <= '0;
      ex_mem_npc_q   <= '0;
      ex_mem_ir_q    <= NOP;
      ex_mem_res_q   <= '0;
      ex_mem_sdata_q <= '0;
      mem_wb_npc_q   <= '0;
      mem_wb_ir_q    <= NOP;
      mem_wb_res_q   <= '0;
    end else begin
      pc_q           <= pc_d;
      if_id_pc_q     <= if_id_pc_d;
      if_id_npc_q    <= if_id_npc_d;
      if_id_ir_q     <= if_id_ir_d;
      id_ex_pc_q     <= id_ex_pc_d;
      id_ex_npc_q    <= id_ex_npc_d;
      id_ex_ir_q     <= id_ex_ir_d;
      id_ex_rs1v_q   <= id_ex_rs1v_d;
      id_ex_rs2v_q   <= id_ex_rs2v_d;
      ex_mem_npc_q   <= id_ex_npc_q;
      ex_mem_ir_q    <= id_ex_ir_q;
      ex_mem_res_q   <= ex_res;
      ex_mem_sdata_q <= ex_rs2;
      mem_wb_npc_q   <= ex_mem_npc_q;
      mem_wb_ir_q    <= ex_mem_ir_q;
      mem_wb_res_q   <= mem_res;
    end
  end

  for (genvar gi = 1; gi < 32; gi++) begin : g_rf
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        rf_q[gi] <= '0;
      else if (dec_wb.wr && dec_wb.rd == 5'(gi))
        rf_q[gi] <= mem_wb_res_q;
    end
  end

  assign bus.pc_addr           = pc_q;
  assign bus.im_command        = rst ? BUS_LOAD : BUS_NONE;
  assign bus.proc2Dmem_addr    = ex_mem_res_q;
  assign bus.proc2mem_data     = ex_mem_sdata_q;
  assign bus.proc2Dmem_command = dec_mem.ld ? BUS_LOAD : dec_mem.st ? BUS_STORE : BUS_NONE;

  assign pipeline_commit_wr_idx  = mem_wb_ir_q[11:7];
  assign pipeline_commit_wr_data = mem_wb_res_q;
  assign pipeline_commit_NPC     = mem_wb_npc_q;
  assign pipeline_commit_wr      = dec_wb.wr;

  assign if_PC_out  = pc_q;
  assign if_NPC_out = pc_q + 32'd4;
  assign if_IR_out  = bus.instruction;
  assign if_id_PC   = if_id_pc_q;
  assign if_id_NPC  = if_id_npc_q;
  assign if_id_IR   = if_id_ir_q;
  assign id_ex_PC   = id_ex_pc_q;
  assign id_ex_NPC  = id_ex_npc_q;
  assign id_ex_IR   = id_ex_ir_q;
  assign ex_mem_NPC = ex_mem_npc_q;
  assign ex_mem_IR  = ex_mem_ir_q;
  assign mem_wb_NPC = mem_wb_npc_q;
  assign mem_wb_IR  = mem_wb_ir_q;
endmodule

// File: tb/tb_pipelined_processor.sv
// Directed bench for pipelined_processor: runs a small program and checks each commit.
module tb_pipelined_processor;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FORWARDING_EN
  localparam int GAP_RAW = 1;
  localparam int GAP_LU  = 2;
`else
  localparam int GAP_RAW = 3;
  localparam int GAP_LU  = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipelined_processor_if bus ();

  logic [4:0]  pipeline_commit_wr_idx;
  logic [31:0] pipeline_commit_wr_data, pipeline_commit_NPC;
  logic        pipeline_commit_wr;
  logic [31:0] if_PC_out, if_NPC_out, if_IR_out;
  logic [31:0] if_id_PC, if_id_NPC, if_id_IR, id_ex_PC, id_ex_NPC, id_ex_IR;
  logic [31:0] ex_mem_NPC, ex_mem_IR, mem_wb_NPC, mem_wb_IR;

  pipelined_processor dut (
    .clk(clk), .rst(rst), .bus(bus),
    .pipeline_commit_wr_idx(pipeline_commit_wr_idx),
    .pipeline_commit_wr_data(pipeline_commit_wr_data),
    .pipeline_commit_NPC(pipeline_commit_NPC),
    .pipeline_commit_wr(pipeline_commit_wr),
    .if_PC_out(if_PC_out), .if_NPC_out(if_NPC_out), .if_IR_out(if_IR_out),
    .if_id_PC(if_id_PC), .if_id_NPC(if_id_NPC), .if_id_IR(if_id_IR),
    .id_ex_PC(id_ex_PC), .id_ex_NPC(id_ex_NPC), .id_ex_IR(id_ex_IR),
    .ex_mem_NPC(ex_mem_NPC), .ex_mem_IR(ex_mem_IR),
    .mem_wb_NPC(mem_wb_NPC), .mem_wb_IR(mem_wb_IR)
  );

  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:63];
  int          st_cnt = 0, ld_cnt = 0;
  logic [31:0] st_addr = '0, st_data = '0, ld_addr = '0;

  assign bus.instruction   = imem[bus.pc_addr[7:2]];
  assign bus.mem2proc_data = dmem[bus.proc2Dmem_addr[7:2]];

  always @(posedge clk) begin
    if (rst && bus.proc2Dmem_command == 2'd2) begin
      dmem[bus.proc2Dmem_addr[7:2]] <= bus.proc2mem_data;
      st_cnt  <= st_cnt + 1;
      st_addr <= bus.proc2Dmem_addr;
      st_data <= bus.proc2mem_data;
    end
    if (rst && bus.proc2Dmem_command == 2'd1) begin
      ld_cnt  <= ld_cnt + 1;
      ld_addr <= bus.proc2Dmem_addr;
    end
  end

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle whose WB stage holds a non-bubble instruction.
  task automatic next_commit(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mem_wb_IR === NOP && n < 20);
  endtask

  typedef struct packed {
    logic [7:0]  gap;
    logic        wr;
    logic [4:0]  idx;
    logic [31:0] data;
    logic [31:0] npc;
  } cmt_t;

  cmt_t exp_c [17];
  int   n;

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = NOP;
    imem[0]  = enc_i(32'd5, 5'd0, 3'b000, 5'd1, 7'h13);        // ADDI x1,x0,5
    imem[1]  = enc_i(32'd3, 5'd1, 3'b000, 5'd2, 7'h13);        // ADDI x2,x1,3
    imem[2]  = enc_i(32'd7, 5'd0, 3'b000, 5'd0, 7'h13);        // ADDI x0,x0,7
    imem[3]  = enc_i(32'd1, 5'd1, 3'b001, 5'd11, 7'h13);       // SLLI x11 (unsupported)
    imem[4]  = enc_b(32'd8, 5'd0, 5'd0, 3'b000);               // BEQ x0,x0,+8
    imem[5]  = enc_i(32'd1, 5'd0, 3'b000, 5'd6, 7'h13);        // wrong path
    imem[6]  = enc_i(32'd9, 5'd0, 3'b000, 5'd7, 7'h13);        // ADDI x7,x0,9
    imem[7]  = enc_i(32'hFFF, 5'd0, 3'b000, 5'd12, 7'h13);     // ADDI x12,x0,-1
    imem[8]  = enc_j(32'd12, 5'd1);                            // JAL x1,+12
    imem[9]  = enc_i(32'd1, 5'd0, 3'b000, 5'd8, 7'h13);        // wrong path
    imem[10] = enc_i(32'd1, 5'd0, 3'b000, 5'd9, 7'h13);        // wrong path
    imem[11] = enc_i(32'd5, 5'd0, 3'b000, 5'd10, 7'h13);       // ADDI x10,x0,5
    imem[12] = enc_i(32'h40, 5'd0, 3'b000, 5'd3, 7'h13);       // ADDI x3,x0,0x40
    imem[13] = enc_s(32'd0, 5'd10, 5'd3);                      // SW x10,0(x3)
    imem[14] = enc_i(32'd0, 5'd3, 3'b010, 5'd4, 7'h03);        // LW x4,0(x3)
    imem[15] = enc_r(7'h00, 5'd4, 5'd4, 3'b000, 5'd5);         // ADD x5,x4,x4
    imem[16] = enc_r(7'h20, 5'd5, 5'd12, 3'b000, 5'd13);       // SUB x13,x12,x5
    imem[17] = enc_r(7'h00, 5'd5, 5'd12, 3'b010, 5'd14);       // SLT x14,x12,x5
    imem[18] = enc_i(32'hF, 5'd5, 3'b100, 5'd15, 7'h13);       // XORI x15,x5,0xF
    imem[19] = enc_j(32'd0, 5'd0);                             // JAL x0,0

    exp_c[0]  = '{8'd4,          1'b1, 5'd1,  32'd5,          32'h04};
    exp_c[1]  = '{8'(GAP_RAW),   1'b1, 5'd2,  32'd8,          32'h08};
    exp_c[2]  = '{8'd1,          1'b0, 5'd0,  32'd0,          32'h0C};
    exp_c[3]  = '{8'd1,          1'b0, 5'd0,  32'd0,          32'h10};
    exp_c[4]  = '{8'd1,          1'b0, 5'd0,  32'd0,          32'h14};
    exp_c[5]  = '{8'd3,          1'b1, 5'd7,  32'd9,          32'h1C};
    exp_c[6]  = '{8'd1,          1'b1, 5'd12, 32'hFFFF_FFFF,  32'h20};
    exp_c[7]  = '{8'd1,          1'b1, 5'd1,  32'h24,         32'h24};
    exp_c[8]  = '{8'd3,          1'b1, 5'd10, 32'd5,          32'h30};
    exp_c[9]  = '{8'd1,          1'b1, 5'd3,  32'h40,         32'h34};
    exp_c[10] = '{8'(GAP_RAW),   1'b0, 5'd0,  32'd0,          32'h38};
    exp_c[11] = '{8'd1,          1'b1, 5'd4,  32'd5,          32'h3C};
    exp_c[12] = '{8'(GAP_LU),    1'b1, 5'd5,  32'd10,         32'h40};
    exp_c[13] = '{8'(GAP_RAW),   1'b1, 5'd13, 32'hFFFF_FFF5,  32'h44};
    exp_c[14] = '{8'd1,          1'b1, 5'd14, 32'd1,          32'h48};
    exp_c[15] = '{8'd1,          1'b1, 5'd15, 32'd5,          32'h4C};
    exp_c[16] = '{8'd1,          1'b0, 5'd0,  32'd0,          32'h50};

    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc_addr",   bus.pc_addr, 32'h0);
    chk("rst_if_id_IR",  if_id_IR, NOP);
    chk("rst_id_ex_IR",  id_ex_IR, NOP);
    chk("rst_ex_mem_IR", ex_mem_IR, NOP);
    chk("rst_mem_wb_IR", mem_wb_IR, NOP);
    chk("rst_if_id_PC",  if_id_PC, 32'h0);
    chk("rst_mem_wb_NPC", mem_wb_NPC, 32'h0);
    chk("rst_commit_wr", 32'(pipeline_commit_wr), 32'd0);
    chk("rst_im_cmd",    32'(bus.im_command), 32'd0);
    rst = 1'b1;
    #1;
    chk("run_im_cmd",    32'(bus.im_command), 32'd1);

    for (int i = 0; i < 17; i++) begin
      next_commit(n);
      $display("commit %0d: gap=%0d wr=%0d idx=%0d data=%h npc=%h", i, n,
               pipeline_commit_wr, pipeline_commit_wr_idx, pipeline_commit_wr_data, pipeline_commit_NPC);
      chk($sformatf("c%0d_gap", i), 32'(n), 32'(exp_c[i].gap));
      chk($sformatf("c%0d_wr", i), 32'(pipeline_commit_wr), 32'(exp_c[i].wr));
      chk($sformatf("c%0d_npc", i), pipeline_commit_NPC, exp_c[i].npc);
      if (exp_c[i].wr) begin
        chk($sformatf("c%0d_idx", i), 32'(pipeline_commit_wr_idx), 32'(exp_c[i].idx));
        chk($sformatf("c%0d_data", i), pipeline_commit_wr_data, exp_c[i].data);
      end
      if (i == 4 || i == 7) begin
        chk($sformatf("c%0d_flush_id_ex", i), id_ex_IR, NOP);
        chk($sformatf("c%0d_flush_ex_mem", i), ex_mem_IR, NOP);
      end
      if (i == 7) chk("jal_refetch_pc", if_id_PC, 32'h2C);
    end

    chk("store_count", 32'(st_cnt), 32'd1);
    chk("store_addr",  st_addr, 32'h40);
    chk("store_data",  st_data, 32'd5);
    chk("load_count",  32'(ld_cnt), 32'd1);
    chk("load_addr",   ld_addr, 32'h40);

    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    $display("async reset: pc=%h if_id_IR=%h mem_wb_IR=%h", bus.pc_addr, if_id_IR, mem_wb_IR);
    chk("mid_pc_addr",   bus.pc_addr, 32'h0);
    chk("mid_if_id_IR",  if_id_IR, NOP);
    chk("mid_id_ex_IR",  id_ex_IR, NOP);
    chk("mid_ex_mem_IR", ex_mem_IR, NOP);
    chk("mid_mem_wb_IR", mem_wb_IR, NOP);
    chk("mid_commit_wr", 32'(pipeline_commit_wr), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    next_commit(n);
    $display("restart commit: gap=%0d idx=%0d data=%h npc=%h", n, pipeline_commit_wr_idx,
             pipeline_commit_wr_data, pipeline_commit_NPC);
    chk("re0_gap",  32'(n), 32'd4);
    chk("re0_data", pipeline_commit_wr_data, 32'd5);
    chk("re0_npc",  pipeline_commit_NPC, 32'h04);
    next_commit(n);
    $display("restart commit: gap=%0d idx=%0d data=%h npc=%h", n, pipeline_commit_wr_idx,
             pipeline_commit_wr_data, pipeline_commit_NPC);
    chk("re1_gap",  32'(n), 32'(GAP_RAW));
    chk("re1_data", pipeline_commit_wr_data, 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipelined_processor.md
# pipelined_processor

Five-stage in-order 32-bit RV32I-subset pipeline (IF, ID, EX, MEM, WB) with separate instruction and data memory ports. It drives both memory ports, which share one bus-command encoding. It exposes per-stage PC/NPC/IR observation ports and a retirement (commit) port so benches can trace execution cycle by cycle. It sits between the instruction memory and data memory models at the top of the core.

## Interface
- RESET_PC, default 32'h0: PC loaded on reset.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pipeline_commit_wr_idx  out  5  destination register of instruction in WB.
- pipeline_commit_wr_data  out  32  value written to that register.
- pipeline_commit_NPC  out  32  NPC of instruction in WB.
- pipeline_commit_wr  out  1  WB instruction writes a register other than x0.
- instruction  in  32  instruction memory read data, combinational from pc_addr.
- pc_addr  out  32  fetch address, equals IF PC.
- im_command  out  2  instruction bus command.
- mem2proc_data  in  32  data memory read data, combinational from proc2Dmem_addr.
- proc2Dmem_addr  out  32  data address from the MEM-stage ALU result.
- proc2Dmem_command  out  2  data bus command.
- proc2mem_data  out  32  store data (rs2).
- if_PC_out, if_NPC_out, if_IR_out  out  32 each  IF-stage PC, PC+4, fetched word.
- if_id_PC, if_id_NPC, if_id_IR  out  32 each  IF/ID register contents.
- id_ex_PC, id_ex_NPC, id_ex_IR  out  32 each  ID/EX register contents.
- ex_mem_NPC, ex_mem_IR  out  32 each  EX/MEM register contents.
- mem_wb_NPC, mem_wb_IR  out  32 each  MEM/WB register contents.

## Operation
- Bus commands are BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2.
- im_command is BUS_LOAD whenever rst is high.
- proc2Dmem_command is LOAD for LW in MEM, STORE for SW in MEM, NONE otherwise.
- Supported instructions: LUI, ADDI, ANDI, ORI, XORI, SLTI, ADD, SUB, AND, OR, XOR, SLT, LW, SW, BEQ, BNE, JAL. Any other opcode is executed as a NOP.
- NOP and bubble encoding is 32'h00000013.
- Register file: 32x32, x0 hardwired to 0. It is written in WB and read in ID, with WB-to-ID bypass when the indices are equal and nonzero.
- Arithmetic is 32-bit two's complement with wrap-around and no traps. SLT/SLTI compare signed.
- Branches and JAL are resolved in EX; the target is PC+imm. JAL writes NPC to rd.
- On a taken branch, IF/ID and ID/EX are flushed to NOP and PC loads the target on the same edge.
- Load-use hazard (LW in EX, consumer in ID): stall PC and IF/ID for 1 cycle and inject a NOP into ID/EX.

## Timing
- Reset (rst low): PC=RESET_PC, all IR registers = NOP, all PC/NPC registers = 0, register file = 0, pipeline_commit_wr=0.
- Releasing reset mid-program restarts execution at RESET_PC.
- Latency: an instruction fetched in cycle n is in WB (commit outputs valid) in cycle n+4, absent stalls.
- Taken branch penalty: 2 bubbles. Load-use penalty: 1 bubble.
- Simultaneous stall and taken branch: the flush wins.
- Stores write memory on the clock edge that ends MEM. Loaded data is registered into MEM/WB on that same edge.

## Configuration
- FORWARDING_EN defined: EX/MEM and MEM/WB results forward to EX operands. The younger (EX/MEM) source wins. Only load-use stalls.
- FORWARDING_EN undefined: no forwarding. ID stalls on any RAW dependency (nonzero rd) with ID/EX or EX/MEM, inserting bubbles until the producer reaches WB.

## Test plan
- Reset release, then ADDI x1,x0,5; ADDI x2,x1,3 -> commit x1=5, then x2=8. With FORWARDING_EN: back-to-back commits. Without it: 2 bubbles between the commits.
- ADDI x3,x0,0x40; SW x1,0(x3); LW x4,0(x3); ADD x5,x4,x4 -> store to 0x40 with data 5, x4=5, x5=10, exactly 1 load-use bubble.
- BEQ x0,x0,+8 at PC 0x10 -> next commit NPC is 0x1C. The two wrong-path IRs appear as NOP in id_ex_IR/ex_mem_IR.
- JAL x1,+12 at PC 0x20 -> x1=0x24, fetch resumes at 0x2C.
- ADDI x0,x0,7 -> pipeline_commit_wr=0, x0 reads 0. Unsupported opcode behaves as NOP.
- Assert rst low mid-program -> all IR=NOP, pc_addr=RESET_PC immediately (asynchronous), commit_wr=0.
